// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg : widths, halt encoding and fetch-queue entry type.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tomasulo_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFC00_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue : DEPTH-entry circular FIFO of fetch entries with flush. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  fetch_entry_t   i_push_data,
  input  logic           i_pop,
  input  logic           i_flush,
  output logic           o_full,
  output logic           o_empty,
  output logic [PTR_W:0] o_count,
  output fetch_entry_t   o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_tail] <= i_push_data;
  end

  assign o_head = o_empty ? '0 : r_mem[r_head];

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : PC sequencing, ROM read control, halt/fault and redirect. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl #(
  parameter int          DEPTH     = 4,
  parameter int          ROM_BYTES = 100,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter logic [31:0] HALT_WORD = tomasulo_pkg::HALT_WORD
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             rom_nrd,
  output logic [tomasulo_pkg::ADDR_W-1:0]  rom_addr,
  input  logic [tomasulo_pkg::INSTR_W-1:0] rom_data,
  output logic                             out_valid,
  output logic [tomasulo_pkg::INSTR_W-1:0] out_instr,
  output logic [tomasulo_pkg::ADDR_W-1:0]  out_pc,
  input  logic                             out_ready,
  input  logic                             redirect,
  input  logic [tomasulo_pkg::ADDR_W-1:0]  redirect_pc,
  output logic                             halted,
  output logic                             fetch_fault
);

  import tomasulo_pkg::*;

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST_PC = ADDR_W'(ROM_BYTES - 4);

  logic [ADDR_W-1:0] r_pc;
  logic              r_halted;
  logic              r_fault;
  logic              w_pc_ok;
  logic              w_fetch_en;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W:0]    w_count;
  fetch_entry_t      w_push_data;
  fetch_entry_t      w_head;

  assign w_pc_ok     = (r_pc <= C_LAST_PC);
  // Reset is folded in so the ROM stays deselected while reset is held.
  assign w_fetch_en  = !rst && !redirect && !r_halted && !r_fault && !w_full && w_pc_ok;
  assign w_pop       = out_valid && out_ready;
  assign w_push_data = '{pc: r_pc, instr: rom_data};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_fetch_en),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else if (redirect) begin
      r_pc     <= {redirect_pc[ADDR_W-1:2], 2'b00};
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_fetch_en) begin
        r_pc <= r_pc + 32'd4;
        if (rom_data == HALT_WORD) r_halted <= 1'b1;
      end
      if (!r_halted && !w_pc_ok) r_fault <= 1'b1;
    end
  end

  assign rom_nrd     = ~w_fetch_en;
  assign rom_addr    = r_pc;
  assign out_valid   = !w_empty;
  assign out_instr   = w_head.instr;
  assign out_pc      = w_head.pc;
  assign halted      = r_halted;
  assign fetch_fault = r_fault;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    w_count <= (PTR_W+1)'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences and random
// traffic compared against a queue-based reference model of the fetch rules.
`default_nettype none

module tb_fetch_ctrl;

  localparam int          DEPTH     = 4;
  localparam int          ROM_BYTES = 100;
  localparam logic [31:0] HALT      = 32'hFC00_0000;
  localparam logic [31:0] LAST_PC   = 32'(ROM_BYTES - 4);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halted;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .DEPTH     (DEPTH),
    .ROM_BYTES (ROM_BYTES),
    .RESET_PC  (32'h0),
    .HALT_WORD (HALT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_nrd     (rom_nrd),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .fetch_fault (fetch_fault)
  );

  // Big-endian byte ROM
  logic [7:0] rom [ROM_BYTES];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    int i;
    if (a > LAST_PC) return 32'h0;
    i = int'(a);
    return {rom[i], rom[i+1], rom[i+2], rom[i+3]};
  endfunction

  always_comb rom_data = rom_nrd ? 32'hDEAD_BEEF : rom_word(rom_addr);

  task automatic set_word(input int a, input logic [31:0] w);
    rom[a]   = w[31:24];
    rom[a+1] = w[23:16];
    rom[a+2] = w[15:8];
    rom[a+3] = w[7:0];
  endtask

  task automatic fill_default();
    for (int a = 0; a < ROM_BYTES; a += 4) set_word(a, 32'hA000_0000 | 32'(a));
  endtask

  task automatic fill_random();
    for (int a = 0; a < ROM_BYTES; a += 4)
      set_word(a, ($urandom_range(0, 9) == 0) ? HALT : $urandom);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of {pc, instr}, program counter and two flags
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_fault;

  function automatic bit m_fetch();
    return !rst && !redirect && !m_halt && !m_fault &&
           (m_q.size() < DEPTH) && (m_pc <= LAST_PC);
  endfunction

  task automatic check_model();
    chk("nrd", {31'b0, rom_nrd}, {31'b0, !m_fetch()});
    chk("rom_addr", rom_addr, m_pc);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    chk("out_pc", out_pc, (m_q.size() != 0) ? m_q[0][63:32] : 32'h0);
    chk("out_instr", out_instr, (m_q.size() != 0) ? m_q[0][31:0] : 32'h0);
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic step_model();
    bit          f;
    logic [31:0] w;
    if (redirect) begin
      m_q.delete();
      m_pc    = redirect_pc & ~32'h3;
      m_halt  = 1'b0;
      m_fault = 1'b0;
    end else begin
      f = m_fetch();
      w = rom_word(m_pc);
      if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
      if (f) begin
        m_q.push_back({m_pc, w});
        if (w == HALT) m_halt = 1'b1;
        m_pc = m_pc + 32'd4;
      end else if (!m_halt && m_pc > LAST_PC) begin
        m_fault = 1'b1;
      end
    end
  endtask

  // Each cycle window starts 2 time units after a rising edge.
  task automatic drive(input bit r, input logic [31:0] rp, input bit rdy);
    redirect    = r;
    redirect_pc = rp;
    out_ready   = rdy;
    #1;
    check_model();
  endtask

  task automatic adv();
    step_model();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input bit r, input logic [31:0] rp, input bit rdy);
    drive(r, rp, rdy);
    adv();
  endtask

  // Asserted mid-window, so outputs are checked before any clock edge.
  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b0;
    m_q.delete();
    m_pc    = 32'h0;
    m_halt  = 1'b0;
    m_fault = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_nrd", {31'b0, rom_nrd}, 32'h1);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rdy;
    bit          e_nrd;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    tbl[0] = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'd4,  1'b1, 32'd0, 32'h1111_1111};
    tbl[2] = '{1'b1, 1'b0, 32'd8,  1'b1, 32'd4, 32'h2222_2222};
    tbl[3] = '{1'b1, 1'b0, 32'd12, 1'b1, 32'd8, 32'h3333_3333};

    @(posedge clk);
    #2;

    // Sequential fetch after reset, one-cycle fetch-to-output latency
    fill_default();
    set_word(0, 32'h1111_1111);
    set_word(4, 32'h2222_2222);
    set_word(8, 32'h3333_3333);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, tbl[i].rdy);
      chk($sformatf("tbl%0d_nrd", i), {31'b0, rom_nrd}, {31'b0, tbl[i].e_nrd});
      chk($sformatf("tbl%0d_addr", i), rom_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].e_instr);
      adv();
    end
    repeat (4) cyc(1'b0, 32'h0, 1'b1);

    // Back-pressure: queue fills, then drains in order
    fill_default();
    do_reset();
    repeat (10) cyc(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("full_addr", rom_addr, 32'd16);
    chk("full_nrd", {31'b0, rom_nrd}, 32'h1);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("full_deq_nrd", {31'b0, rom_nrd}, 32'h1);
    chk("full_head_pc", out_pc, 32'd0);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("resume_nrd", {31'b0, rom_nrd}, 32'h0);
    chk("resume_addr", rom_addr, 32'd16);
    adv();
    repeat (8) cyc(1'b0, 32'h0, 1'b1);

    // Halt word at 12 is delivered, then fetch stops
    fill_default();
    set_word(12, HALT);
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (out_valid && out_pc == 32'd12 && out_instr == HALT) seen = 1'b1;
      adv();
    end
    drive(1'b0, 32'h0, 1'b1);
    chk("halt_seen", {31'b0, seen}, 32'h1);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_nrd", {31'b0, rom_nrd}, 32'h1);
    chk("halt_addr", rom_addr, 32'd16);
    adv();

    // Redirect with three entries queued
    fill_default();
    do_reset();
    repeat (3) cyc(1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h2A, 1'b1);
    chk("redir_nrd", {31'b0, rom_nrd}, 32'h1);
    adv();
    drive(1'b0, 32'h0, 1'b0);
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_addr", rom_addr, 32'h28);
    chk("redir_fetch", {31'b0, rom_nrd}, 32'h0);
    adv();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_out_valid", {31'b0, out_valid}, 32'h1);
    chk("redir_out_pc", out_pc, 32'h28);
    chk("redir_out_instr", out_instr, 32'hA000_0028);
    adv();

    // Run off the end of the ROM, then recover via redirect
    fill_default();
    do_reset();
    cyc(1'b1, 32'd88, 1'b1);
    repeat (4) cyc(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("fault_set", {31'b0, fetch_fault}, 32'h1);
    chk("fault_nrd", {31'b0, rom_nrd}, 32'h1);
    chk("fault_addr", rom_addr, 32'd100);
    adv();
    cyc(1'b1, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    chk("fault_clear", {31'b0, fetch_fault}, 32'h0);
    chk("fault_refetch", {31'b0, rom_nrd}, 32'h0);
    adv();

    // Asynchronous reset with two entries queued (checks inside do_reset)
    fill_default();
    do_reset();
    repeat (2) cyc(1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    do_reset();
    repeat (3) cyc(1'b0, 32'h0, 1'b1);

    // Randomized traffic against the reference model
    for (int round = 0; round < 3; round++) begin
      fill_random();
      do_reset();
      for (int i = 0; i < 300; i++)
        cyc($urandom_range(0, 15) == 0, 32'($urandom_range(0, 127)),
            $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction fetch controller for the Tomasulo core. It sequences the byte-addressed, big-endian, combinational instruction ROM (active-low read enable, 32-bit word per read) and maintains the program counter. Fetched words go into a small circular instruction queue, and the issue stage drains the queue through a valid/ready handshake. Branch resolution redirects fetch and flushes the queue.

Parameters:
DEPTH, 4, instruction queue entries (power of two, ≥2)
ROM_BYTES, 100, ROM size in bytes; highest legal fetch address is ROM_BYTES-4
RESET_PC, 0, PC value after reset (word aligned)
HALT_WORD, 32'hFC000000, encoding of the halt instruction

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
rom_nrd  out  1  ROM read enable, active low; combinational
rom_addr  out  32  ROM byte address; combinational, always equals pc
rom_data  in  32  ROM word, valid in the same cycle rom_nrd=0
out_valid  out  1  queue head valid
out_instr  out  32  head instruction
out_pc  out  32  byte address of head instruction
out_ready  in  1  issue stage accepts head this cycle
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  32  new PC; bits [1:0] forced to 0
halted  out  1  halt word fetched; fetch stopped
fetch_fault  out  1  PC beyond ROM_BYTES-4; fetch stopped (sticky)

Behaviour:
- Reset (asynchronous) sets: pc=RESET_PC; queue empty (head=tail=count=0); halted=0; fetch_fault=0. Resulting outputs: out_valid=0, rom_nrd=1, rom_addr=RESET_PC.
- Fetch condition: fetch_en = !redirect && !halted && !fetch_fault && count<DEPTH && pc<=ROM_BYTES-4. A full queue blocks fetch even if it dequeues in the same cycle.
- rom_nrd = ~fetch_en, combinational. rom_addr = pc.
- On fetch_en at the clock edge:
  - Enqueue {pc, rom_data} at tail; tail wraps modulo DEPTH.
  - pc <= pc+4 (32-bit, unsigned).
  - If rom_data==HALT_WORD: halted<=1. The halt word is still enqueued and pc still advances.
- Fault: if !halted, !redirect and pc>ROM_BYTES-4, set fetch_fault<=1. No enqueue.
- Output and dequeue:
  - out_valid = (count!=0). out_instr and out_pc come from the head entry, zero when empty.
  - Dequeue when out_valid && out_ready; head wraps modulo DEPTH.
- Count: enqueue and dequeue in the same cycle leave count unchanged. count never exceeds DEPTH and never underflows.
- Redirect has priority over all other events:
  - Queue cleared (count=0, head=tail=0). A dequeue in that cycle is discarded.
  - pc <= {redirect_pc[31:2],2'b00}.
  - halted and fetch_fault cleared.
  - No fetch in the redirect cycle (rom_nrd=1). Fetch resumes the next cycle.
  - Redirect while halted or faulted restarts fetch normally.
- Latency:
  - Word at address A fetched in cycle N is visible at out_* in cycle N+1.
  - Minimum redirect-to-out_valid latency is 2 cycles.
- Reset asserted mid-operation abandons all queued entries immediately.

Decomposition:
- Shared package tomasulo_pkg:
  - INSTR_W=32 and ADDR_W=32.
  - HALT_WORD constant.
  - Packed struct fetch_entry_t {pc, instr}.
- Sub-module fetch_queue: DEPTH-entry circular FIFO of fetch_entry_t with push, pop, flush, full, empty and count.
- fetch_ctrl keeps the PC, the fetch-enable logic, the halt and fault flags, and the redirect logic.

Test Plan:
- Reset release, ROM words 0x11111111/0x22222222/0x33333333 at 0/4/8, out_ready=1 -> rom_addr 0,4,8 on consecutive cycles; out_pc 0,4,8 with matching out_instr one cycle later.
- out_ready=0 for 10 cycles -> exactly 4 fetches (pc=16), then rom_nrd=1. Raise out_ready -> entries drain in order, and fetch resumes at 16 one cycle after count<4.
- HALT_WORD at address 12 -> entry with out_pc=12 delivered. halted=1 the cycle after the fetch. No further rom_nrd=0.
- redirect=1, redirect_pc=0x2A while queue holds 3 entries -> next cycle out_valid=0, pc=0x28. Following cycle fetches 0x28, and out_pc=0x28 the cycle after.
- Run sequentially from 88 with ROM_BYTES=100 -> fetches 88, 92, 96. fetch_fault=1 at pc=100, no fetch. A redirect to 0 clears the fault.
- Assert rst asynchronously with 2 entries queued -> out_valid=0 and rom_addr=RESET_PC immediately, before the next clock edge.
